// File: rtl/matrixmult_pkg.sv
// Shared constants and state type for the matrix-multiplier operand feeder.
package matrixmult_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int N          = 4;
  localparam int BEATS      = N * N;
  localparam int M_BASE     = 0;
  localparam int V_BASE     = 16;
  localparam int ENTRIES    = BEATS + N;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/matrixmult_operand_feeder_if.sv
// Operand stream between the feeder (master) and the multiplier (slave).
// With MATRIXMULT_FEEDER_TLAST_EN defined the stream also carries tlast and row_idx.
interface matrixmult_operand_feeder_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  a_tvalid;
  logic                  b_tvalid;
  logic                  tready;
`ifdef MATRIXMULT_FEEDER_TLAST_EN
  logic                  tlast;
  logic [1:0]            row_idx;

  modport master (output a, b, a_tvalid, b_tvalid, tlast, row_idx, input tready);
  modport slave  (input a, b, a_tvalid, b_tvalid, tlast, row_idx, output tready);
`else
  modport master (output a, b, a_tvalid, b_tvalid, input tready);
  modport slave  (input a, b, a_tvalid, b_tvalid, output tready);
`endif

endinterface

// File: rtl/matrixmult_operand_regfile.sv
// 20-word operand store: M[0..15] then V[0..3], one write port, two async read ports.
module matrixmult_operand_regfile
  import matrixmult_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wrEn,
  input  logic [4:0]            i_wrAddr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic [1:0]            i_row,
  input  logic [1:0]            i_col,
  output logic [DATA_WIDTH-1:0] o_mData,
  output logic [DATA_WIDTH-1:0] o_vData
);

  logic [DATA_WIDTH-1:0] r_mem [ENTRIES];
  logic [4:0]            w_mIdx;
  logic [4:0]            w_vIdx;

  assign w_mIdx = 5'(M_BASE) + {1'b0, i_row, i_col};
  assign w_vIdx = 5'(V_BASE) + {3'b000, i_col};

  // Addresses 20..31 fall outside the map and are silently ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wrEn && (i_wrAddr < 5'(ENTRIES))) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_mData = r_mem[w_mIdx];
  assign o_vData = r_mem[w_vIdx];

endmodule

// File: rtl/matrixmult_operand_feeder.sv
// Streams the stored 4x4 matrix and pixel vector as 16 (M[r][c], V[c]) operand pairs.
// Optional macro MATRIXMULT_FEEDER_TLAST_EN adds registered tlast/row_idx on the stream.
module matrixmult_operand_feeder
  import matrixmult_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err,
  matrixmult_operand_feeder_if.master strm
);

  if (N != 4) begin : g_badN
    $error("matrixmult_operand_feeder supports N=4 only");
  end

  state_t                r_state;
  state_t                w_nextState;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_wrErr;
  logic                  r_tlast;
  logic [1:0]            r_rowIdx;

  logic                  w_wrAccept;
  logic                  w_hs;
  logic                  w_lastBeat;
  logic                  w_startFrame;
  logic                  w_frameEnd;
  logic                  w_load;
  logic [3:0]            w_loadIdx;
  logic [DATA_WIDTH-1:0] w_mData;
  logic [DATA_WIDTH-1:0] w_vData;
  logic [DATA_WIDTH-1:0] w_aNext;
  logic [DATA_WIDTH-1:0] w_bNext;

  assign w_wrAccept   = wr_en && (r_state != STREAM);
  assign w_hs         = r_valid && strm.tready;
  assign w_lastBeat   = (r_cnt == 4'(BEATS - 1));
  assign w_startFrame = start && (r_state != STREAM);
  assign w_frameEnd   = (r_state == STREAM) && w_hs && w_lastBeat;

  matrixmult_operand_regfile #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_wrEn   (w_wrAccept),
    .i_wrAddr (wr_addr),
    .i_wrData (wr_data),
    .i_row    (w_loadIdx[3:2]),
    .i_col    (w_loadIdx[1:0]),
    .o_mData  (w_mData),
    .o_vData  (w_vData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = STREAM;
      STREAM:  if (w_frameEnd) w_nextState = DONE;
      DONE:    w_nextState = start ? STREAM : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A write landing on the same edge as a beat load is forwarded, so a frame
  // started together with a write streams the freshly written word.
  always_comb begin
    w_load    = 1'b0;
    w_loadIdx = r_cnt;
    if (w_startFrame) begin
      w_load    = 1'b1;
      w_loadIdx = '0;
    end else if ((r_state == STREAM) && w_hs && !w_lastBeat) begin
      w_load    = 1'b1;
      w_loadIdx = r_cnt + 4'd1;
    end
    w_aNext = w_mData;
    w_bNext = w_vData;
    if (w_wrAccept && (wr_addr == (5'(M_BASE) + {1'b0, w_loadIdx}))) begin
      w_aNext = wr_data;
    end
    if (w_wrAccept && (wr_addr == (5'(V_BASE) + {3'b000, w_loadIdx[1:0]}))) begin
      w_bNext = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wrErr  <= 1'b0;
      r_tlast  <= 1'b0;
      r_rowIdx <= '0;
    end else begin
      r_busy  <= (w_nextState == STREAM);
      r_done  <= (w_nextState == DONE);
      r_wrErr <= wr_en && (r_state == STREAM);
      if (w_load) begin
        r_a      <= w_aNext;
        r_b      <= w_bNext;
        r_valid  <= 1'b1;
        r_cnt    <= w_loadIdx;
        r_tlast  <= (w_loadIdx[1:0] == 2'd3);
        r_rowIdx <= w_loadIdx[3:2];
      end else if (w_frameEnd) begin
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end
    end
  end

  assign strm.a        = r_a;
  assign strm.b        = r_b;
  assign strm.a_tvalid = r_valid;
  assign strm.b_tvalid = r_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign wr_err        = r_wrErr;

`ifdef MATRIXMULT_FEEDER_TLAST_EN
  assign strm.tlast   = r_tlast;
  assign strm.row_idx = r_rowIdx;
`else
  logic w_unusedTlast;
  assign w_unusedTlast = r_tlast ^ (^r_rowIdx);
`endif

endmodule

// File: tb/tb_matrixmult_operand_feeder.sv
// Directed bench for matrixmult_operand_feeder: a scoreboard queue holds the expected
// beats of each frame and a negedge monitor pops them on every handshake.
module tb_matrixmult_operand_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        wr_err;

  matrixmult_operand_feeder_if #(.DATA_WIDTH(32)) strm ();

  matrixmult_operand_feeder #(
    .DATA_WIDTH (32),
    .N          (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .wr_err  (wr_err),
    .strm    (strm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          idx;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] mModel [16];
  logic [31:0] vModel [4];
  int          errors = 0;
  int          checks = 0;
  int          hsCount = 0;
  int          doneCount = 0;
  logic        prevStall = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] data,
                               input logic st);
    wr_en   = we;
    wr_addr = addr;
    wr_data = data;
    start   = st;
  endtask

  task automatic writeWord(input logic [4:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 1'b0);
    if (addr < 5'd16) mModel[addr[3:0]] = data;
    else if (addr < 5'd20) vModel[addr[1:0]] = data;
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic pushFrame();
    beat_t e;
    for (int i = 0; i < 16; i++) begin
      e.a   = mModel[i];
      e.b   = vModel[i % 4];
      e.idx = i;
      sb.push_back(e);
    end
  endtask

  task automatic waitDone(input int bound, input string tag);
    int n;
    n = 0;
    while ((done !== 1'b1) && (n < bound)) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  // Monitor: every valid cycle must present the scoreboard head; a handshake pops it.
  always @(negedge clk) begin
    if (reset) begin
      if (prevStall) checkOutput("stall_valid_held", 32'(strm.a_tvalid), 32'd1);
      if (strm.a_tvalid === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          checkOutput("beat_a", strm.a, sb[0].a);
          checkOutput("beat_b", strm.b, sb[0].b);
          checkOutput("beat_b_tvalid", 32'(strm.b_tvalid), 32'd1);
`ifdef MATRIXMULT_FEEDER_TLAST_EN
          checkOutput("beat_tlast", 32'(strm.tlast), 32'((sb[0].idx % 4) == 3));
          checkOutput("beat_row_idx", 32'(strm.row_idx), 32'(sb[0].idx / 4));
`endif
          if (strm.tready === 1'b1) begin
            void'(sb.pop_front());
            hsCount++;
          end
        end
      end
      prevStall = (strm.a_tvalid === 1'b1) && (strm.tready !== 1'b1);
      if (done === 1'b1) doneCount++;
    end else begin
      prevStall = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rows [16];
    int hsBefore;
    int doneBefore;
    int k;
    rows = '{32'h4124CCCD, 32'h40C80000, 32'h40A9999A, 32'h3C4CCCCD,
             32'h40600000, 32'h40980000, 32'h4111999A, 32'h43164CCD,
             32'hBF07AE14, 32'h4141999A, 32'hC1691EB8, 32'h4040A3D7,
             32'h3C4CCCCD, 32'h40A9999A, 32'h40C80000, 32'h4124CCCD};
    for (int i = 0; i < 16; i++) mModel[i] = 32'h0;
    for (int i = 0; i < 4; i++) vModel[i] = 32'h0;
    strm.tready = 1'b0;

    // Reset values
    tick();
    tick();
    checkOutput("rst_a", strm.a, 32'h0);
    checkOutput("rst_b", strm.b, 32'h0);
    checkOutput("rst_valid", 32'(strm.a_tvalid), 32'd0);
    checkOutput("rst_bvalid", 32'(strm.b_tvalid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr_err", 32'(wr_err), 32'd0);
    reset = 1'b1;
    tick();

    // Load everything except M[0][0]; that word arrives together with start
    for (int i = 1; i < 16; i++) writeWord(5'(i), rows[i]);
    for (int i = 0; i < 4; i++) writeWord(5'(16 + i), rows[8 + i]);
    writeWord(5'd22, 32'hDEADBEEF);
    strm.tready = 1'b1;
    applyStimulus(1'b1, 5'd0, rows[0], 1'b1);
    mModel[0] = rows[0];
    pushFrame();
    hsBefore = hsCount;
    doneBefore = doneCount;
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      checkOutput("fr_busy", 32'(busy), 32'd1);
      checkOutput("fr_valid", 32'(strm.a_tvalid), 32'd1);
      checkOutput("fr_done_low", 32'(done), 32'd0);
      if (i == 1) begin
        checkOutput("fr_beat0_a", strm.a, 32'h4124CCCD);
        checkOutput("fr_beat0_b", strm.b, 32'hBF07AE14);
      end
      if (i == 8) begin
        checkOutput("fr_beat7_a", strm.a, 32'h43164CCD);
        checkOutput("fr_beat7_b", strm.b, 32'h4040A3D7);
      end
      if (i == 16) begin
        checkOutput("fr_beat15_a", strm.a, 32'h4124CCCD);
        checkOutput("fr_beat15_b", strm.b, 32'h4040A3D7);
      end
      tick();
    end
    checkOutput("fr_done_T17", 32'(done), 32'd1);
    checkOutput("fr_busy_T17", 32'(busy), 32'd0);
    checkOutput("fr_valid_T17", 32'(strm.a_tvalid), 32'd0);
    checkOutput("fr_a_hold", strm.a, 32'h4124CCCD);
    checkOutput("fr_b_hold", strm.b, 32'h4040A3D7);
    tick();
    checkOutput("fr_done_pulse", 32'(done), 32'd0);
    checkOutput("fr_hs_count", 32'(hsCount - hsBefore), 32'd16);
    checkOutput("fr_done_count", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("fr_sb_empty", 32'(sb.size()), 32'd0);

    // Stalled frame: tready pattern 1,0,0 repeating
    hsBefore = hsCount;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    pushFrame();
    tick();
    start = 1'b0;
    k = 0;
    while ((done !== 1'b1) && (k < 200)) begin
      strm.tready = ((k % 3) == 0);
      tick();
      k++;
    end
    checkOutput("st_done", 32'(done), 32'd1);
    checkOutput("st_hs_count", 32'(hsCount - hsBefore), 32'd16);
    checkOutput("st_sb_empty", 32'(sb.size()), 32'd0);
    strm.tready = 1'b1;
    tick();

    // Write during STREAM is dropped and flagged
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    pushFrame();
    tick();
    start = 1'b0;
    tick();
    applyStimulus(1'b1, 5'd16, 32'h00000000, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("we_err_pulse", 32'(wr_err), 32'd1);
    tick();
    checkOutput("we_err_clear", 32'(wr_err), 32'd0);
    waitDone(40, "we_done");
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    pushFrame();
    tick();
    start = 1'b0;
    checkOutput("we_v0_kept", strm.b, 32'hBF07AE14);
    waitDone(40, "we_done2");
    tick();

    // start during STREAM ignored; start in DONE chains a new frame
    doneBefore = doneCount;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    pushFrame();
    tick();
    for (int i = 1; i <= 16; i++) begin
      start = (i == 4) || (i == 10);
      tick();
    end
    checkOutput("ig_done", 32'(done), 32'd1);
    start = 1'b1;
    pushFrame();
    tick();
    start = 1'b0;
    checkOutput("ig_chain_valid", 32'(strm.a_tvalid), 32'd1);
    checkOutput("ig_chain_busy", 32'(busy), 32'd1);
    checkOutput("ig_one_done", 32'(doneCount - doneBefore), 32'd1);
    waitDone(40, "ig_done2");
    tick();
    checkOutput("ig_idle", 32'(done), 32'd0);
    checkOutput("ig_two_done", 32'(doneCount - doneBefore), 32'd2);
    checkOutput("ig_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-frame at beat 5
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    pushFrame();
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    doneBefore = doneCount;
    reset = 1'b0;
    #1;
    sb.delete();
    checkOutput("rs_valid", 32'(strm.a_tvalid), 32'd0);
    checkOutput("rs_busy", 32'(busy), 32'd0);
    checkOutput("rs_a", strm.a, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rs_no_done", 32'(doneCount - doneBefore), 32'd0);
    checkOutput("rs_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) mModel[i] = 32'h0;
    for (int i = 0; i < 4; i++) vModel[i] = 32'h0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    pushFrame();
    tick();
    start = 1'b0;
    checkOutput("rs_zero_a", strm.a, 32'h0);
    waitDone(40, "rs_done");
    tick();
    checkOutput("rs_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrixmult_operand_feeder.md
Name: matrixmult_operand_feeder

Overview:
- Producer end of the sequential matrix-multiplier operand stream.
- Holds a 4x4 float32 matrix and a 4-element float32 pixel vector, loaded through a simple write port.
- On `start`, emits the 16 operand pairs as a valid/ready stream on `a`/`b`: a = M[r][c], b = V[c], row-major (r outer, c inner).
- Sits between the pixel/matrix source and `matrixmultiplier`; replaces hand-sequenced stimulus on `a`, `b` and `*_tvalid`.

Parameters:
- DATA_WIDTH, 32, operand width (IEEE-754 single).
- N, 4, matrix dimension. The block supports N=4 only; other values are a compile-time error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  storage write strobe.
- wr_addr  in  5  0..15 = M[addr[3:2]][addr[1:0]]; 16..19 = V[addr-16]; 20..31 ignored.
- wr_data  in  DATA_WIDTH  write data.
- start  in  1  one-cycle request to stream the stored operands.
- a  out  DATA_WIDTH  matrix operand.
- b  out  DATA_WIDTH  vector operand.
- a_tvalid  out  1  `a` valid.
- b_tvalid  out  1  `b` valid; always equal to `a_tvalid`.
- tready  in  1  downstream accept; one ready serves both channels.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse after the last beat is accepted.
- wr_err  out  1  one-cycle pulse when a write is dropped because the block is busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - All storage cleared to 0.
  - a=0, b=0, a_tvalid=b_tvalid=0, busy=0, done=0, wr_err=0.
  - State = IDLE, beat counter = 0.
- Storage write:
  - Accepted when wr_en=1 in IDLE or DONE; takes effect on the next edge.
  - wr_en=1 in STREAM: write dropped, wr_err pulses for 1 cycle.
- States:
  - IDLE, start=1 -> STREAM. Counter=0, a/b loaded with beat 0, tvalid=1 on the next edge. Latency start->first valid = 1 cycle.
  - STREAM, handshake (tvalid & tready):
    - counter<15: counter+1; a/b load the next beat on the same edge.
    - counter==15: tvalid=0, a/b hold their last value, state -> DONE.
  - DONE: done=1 for exactly 1 cycle, then -> IDLE. start=1 in DONE goes directly to STREAM, so back-to-back frames have a 1-cycle gap.
- Counter: 4 bits. r = counter[3:2], c = counter[1:0]. Wraps to 0 only on frame end.
- Stream protocol:
  - Once tvalid=1, a/b/tvalid are held stable until a handshake occurs.
  - tready low for any number of cycles stalls the stream with no loss or duplication.
  - tready may be high while tvalid=0; this has no effect.
- start during STREAM is ignored: not queued, no error.
- A simultaneous write and start in IDLE: the write lands and the frame streams the new value.
- Full-rate frame (tready tied high): start at T; beats at T+1..T+16; done at T+17; busy high T+1..T+16.
- Reset asserted mid-frame: the frame is aborted immediately and no done is produced. After release the block is in IDLE with storage zeroed.
- All outputs are registered; there is no combinational path from tready to any output.

Optional Feature:
- Macro: MATRIXMULT_FEEDER_TLAST_EN.
- Defined:
  - Adds output `tlast` (1 bit), high with any beat where c==3 (row boundary), so the consumer can frame dot products.
  - Adds output `row_idx` (2 bits), giving the current r.
  - Both are registered, reset to 0, and follow the same hold-while-stalled rule.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Shared package `matrixmult_pkg`:
  - DATA_WIDTH, N, BEATS (=16).
  - Address map constants: M_BASE=0, V_BASE=16.
  - State enum {IDLE, STREAM, DONE}.
- One sub-module, `matrixmult_operand_regfile`: 20x32 storage with write port and two combinational read ports (M[r][c], V[c]).
- FSM and output registers stay in the top module.

Test Plan:
- Load the 4x4 matrix rows {4124CCCD,40C80000,40A9999A,3C4CCCCD}, {40600000,40980000,4111999A,43164CCD}, {BF07AE14,4141999A,C1691EB8,4040A3D7}, {3C4CCCCD,40A9999A,40C80000,4124CCCD}; V={BF07AE14,4141999A,C1691EB8,4040A3D7}; start; tready=1 -> 16 beats on consecutive cycles. Beat 0 a=4124CCCD b=BF07AE14; beat 7 a=43164CCD b=4040A3D7; beat 15 a=4124CCCD b=4040A3D7; done at T+17.
- Same load; tready pattern 1,0,0,1,... -> a/b stable through every stall; exactly 16 handshakes in order; no duplicate beats.
- wr_en to addr 16 (wr_data=00000000) during STREAM -> wr_err pulse; the next frame still streams V[0]=BF07AE14.
- start pulsed at beats 3 and 9 -> ignored; one done only. Then start in the DONE cycle -> new frame, first valid 1 cycle later.
- Assert reset at beat 5 -> tvalid=0, busy=0 immediately; no done. After release, start -> all a=b=00000000.
- With MATRIXMULT_FEEDER_TLAST_EN defined: tlast high on beats 3, 7, 11, 15 only; row_idx steps 0..3.
